// File: rtl/fdma_pkg.sv
// Shared widths, defaults and FSM encodings for the FDMA BRAM responder.
package fdma_pkg;

  localparam int unsigned FDMA_DATA_W     = 128;
  localparam int unsigned FDMA_ADDR_W     = 32;
  localparam int unsigned FDMA_SIZE_W     = 16;
  localparam int unsigned FDMA_MEM_DEPTH  = 4096;
  localparam int unsigned BEAT_BYTES_LOG2 = $clog2(FDMA_DATA_W / 8);

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fdma_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module fdma_sdp_ram #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register only loads on a read, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fdma_bram_slave.sv
// FDMA slave backed by on-chip RAM: independent write and read burst engines
// plus a sticky flag for bursts that wrap past the end of the memory.
module fdma_bram_slave
  import fdma_pkg::*;
#(
  parameter int unsigned DATA_W    = FDMA_DATA_W,
  parameter int unsigned ADDR_W    = FDMA_ADDR_W,
  parameter int unsigned SIZE_W    = FDMA_SIZE_W,
  parameter int unsigned MEM_DEPTH = FDMA_MEM_DEPTH
) (
  input  logic              ui_clk,
  input  logic              fdma_rstn,
  input  logic [ADDR_W-1:0] fdma_waddr,
  input  logic              fdma_wareq,
  input  logic [SIZE_W-1:0] fdma_wsize,
  output logic              fdma_wbusy,
  input  logic [DATA_W-1:0] fdma_wdata,
  output logic              fdma_wvalid,
  input  logic              fdma_wready,
  input  logic [ADDR_W-1:0] fdma_raddr,
  input  logic              fdma_rareq,
  input  logic [SIZE_W-1:0] fdma_rsize,
  output logic              fdma_rbusy,
  output logic [DATA_W-1:0] fdma_rdata,
  output logic              fdma_rvalid,
  input  logic              fdma_rready,
  output logic              fdma_err
);

  localparam int unsigned BB_LOG2 = (DATA_W == FDMA_DATA_W) ? BEAT_BYTES_LOG2
                                                            : $clog2(DATA_W / 8);
  localparam int unsigned MEM_AW  = $clog2(MEM_DEPTH);
  localparam int unsigned SUM_W   = ((SIZE_W > MEM_AW) ? SIZE_W : MEM_AW) + 1;

  // ---------------- write channel ----------------
  wr_state_e         w_state_q;
  logic [MEM_AW-1:0] w_addr_q;
  logic [SIZE_W-1:0] w_cnt_q;
  logic [MEM_AW-1:0] w_start;
  logic              w_accept;
  logic              w_wraps;

  assign w_start     = MEM_AW'(fdma_waddr >> BB_LOG2);
  assign w_accept    = (w_state_q == W_IDLE) && fdma_wareq;
  assign w_wraps     = (SUM_W'(w_start) + SUM_W'(fdma_wsize)) > SUM_W'(MEM_DEPTH);
  assign fdma_wbusy  = (w_state_q == W_BURST);
  assign fdma_wvalid = (w_state_q == W_BURST) && (w_cnt_q != '0) && fdma_wready;

  always_ff @(posedge ui_clk) begin
    if (!fdma_rstn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (fdma_wareq) begin
            w_state_q <= W_BURST;
            w_addr_q  <= w_start;
            w_cnt_q   <= fdma_wsize;
          end
        end
        W_BURST: begin
          if (w_cnt_q == '0) begin
            w_state_q <= W_IDLE;
          end else if (fdma_wvalid) begin
            w_addr_q <= w_addr_q + MEM_AW'(1);
            w_cnt_q  <= w_cnt_q - SIZE_W'(1);
            if (w_cnt_q == SIZE_W'(1)) w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_e         r_state_q;
  logic [MEM_AW-1:0] r_addr_q;
  logic [SIZE_W-1:0] r_issue_q;
  logic [SIZE_W-1:0] r_beat_q;
  logic              r_valid_q;
  logic [MEM_AW-1:0] r_start;
  logic              r_accept;
  logic              r_wraps;
  logic              r_issue;
  logic              r_xfer;

  assign r_start     = MEM_AW'(fdma_raddr >> BB_LOG2);
  assign r_accept    = (r_state_q == R_IDLE) && fdma_rareq;
  assign r_wraps     = (SUM_W'(r_start) + SUM_W'(fdma_rsize)) > SUM_W'(MEM_DEPTH);
  // A new RAM read is launched only when the output slot is free or draining.
  assign r_issue     = (r_state_q == R_BURST) && (r_issue_q != '0) &&
                       (!r_valid_q || fdma_rready);
  assign r_xfer      = r_valid_q && fdma_rready;
  assign fdma_rbusy  = (r_state_q == R_BURST);
  assign fdma_rvalid = r_valid_q;

  always_ff @(posedge ui_clk) begin
    if (!fdma_rstn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_issue_q <= '0;
      r_beat_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      if (r_issue)     r_valid_q <= 1'b1;
      else if (r_xfer) r_valid_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (fdma_rareq) begin
            r_state_q <= R_BURST;
            r_addr_q  <= r_start;
            r_issue_q <= fdma_rsize;
            r_beat_q  <= fdma_rsize;
          end
        end
        R_BURST: begin
          if (r_issue) begin
            r_addr_q  <= r_addr_q + MEM_AW'(1);
            r_issue_q <= r_issue_q - SIZE_W'(1);
          end
          if (r_beat_q == '0) begin
            r_state_q <= R_IDLE;
          end else if (r_xfer) begin
            r_beat_q <= r_beat_q - SIZE_W'(1);
            if (r_beat_q == SIZE_W'(1)) r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Sticky wrap flag, set by either channel at accept.
  logic err_q;

  always_ff @(posedge ui_clk) begin
    if (!fdma_rstn)                                        err_q <= 1'b0;
    else if ((w_accept && w_wraps) || (r_accept && r_wraps)) err_q <= 1'b1;
  end

  assign fdma_err = err_q;

  fdma_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .AW     (MEM_AW)
  ) u_ram (
    .clk     (ui_clk),
    .rst_n   (fdma_rstn),
    .we_i    (fdma_wvalid),
    .waddr_i (w_addr_q),
    .wdata_i (fdma_wdata),
    .re_i    (r_issue),
    .raddr_i (r_addr_q),
    .rdata_o (fdma_rdata)
  );

  // Only the word-index bits of the byte addresses are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fdma_waddr, fdma_raddr};

endmodule

// File: tb/tb_fdma_bram_slave.sv
// Bench for fdma_bram_slave: directed bursts plus randomized ones, checked
// against a word-array memory model and the protocol timing rules.
module tb_fdma_bram_slave;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 32;
  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 4096;

  logic          ui_clk = 1'b0;
  logic          fdma_rstn;
  logic [AW-1:0] fdma_waddr;
  logic          fdma_wareq;
  logic [SW-1:0] fdma_wsize;
  logic          fdma_wbusy;
  logic [DW-1:0] fdma_wdata;
  logic          fdma_wvalid;
  logic          fdma_wready;
  logic [AW-1:0] fdma_raddr;
  logic          fdma_rareq;
  logic [SW-1:0] fdma_rsize;
  logic          fdma_rbusy;
  logic [DW-1:0] fdma_rdata;
  logic          fdma_rvalid;
  logic          fdma_rready;
  logic          fdma_err;

  int            vec_cnt  = 0;
  int            miss_cnt = 0;
  bit            exp_err  = 1'b0;
  logic [DW-1:0] model_mem [DEPTH];

  always #5 ui_clk = ~ui_clk;

  fdma_bram_slave #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .SIZE_W    (SW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .ui_clk      (ui_clk),
    .fdma_rstn   (fdma_rstn),
    .fdma_waddr  (fdma_waddr),
    .fdma_wareq  (fdma_wareq),
    .fdma_wsize  (fdma_wsize),
    .fdma_wbusy  (fdma_wbusy),
    .fdma_wdata  (fdma_wdata),
    .fdma_wvalid (fdma_wvalid),
    .fdma_wready (fdma_wready),
    .fdma_raddr  (fdma_raddr),
    .fdma_rareq  (fdma_rareq),
    .fdma_rsize  (fdma_rsize),
    .fdma_rbusy  (fdma_rbusy),
    .fdma_rdata  (fdma_rdata),
    .fdma_rvalid (fdma_rvalid),
    .fdma_rready (fdma_rready),
    .fdma_err    (fdma_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_all_zero(input string tag);
    chk1({tag, "_wbusy"},  fdma_wbusy,  1'b0);
    chk1({tag, "_wvalid"}, fdma_wvalid, 1'b0);
    chk1({tag, "_rbusy"},  fdma_rbusy,  1'b0);
    chk1({tag, "_rvalid"}, fdma_rvalid, 1'b0);
    chk1({tag, "_err"},    fdma_err,    1'b0);
    chk({tag, "_rdata"},   fdma_rdata,  '0);
  endtask

  // Write burst; abort_at >= 0 pulses reset once that many beats are written.
  task automatic do_write(input logic [AW-1:0] baddr, input int unsigned n,
                          input int unsigned stall_pct, input bit idx_data,
                          input int abort_at);
    int unsigned   wa;
    int unsigned   left;
    int            beat;
    logic [DW-1:0] d;
    logic          exp_v;
    wa   = (baddr >> 4) % DEPTH;
    left = n;
    beat = 0;
    @(posedge ui_clk); #1;
    fdma_waddr  = baddr;
    fdma_wsize  = SW'(n);
    fdma_wareq  = 1'b1;
    fdma_wready = 1'b0;
    @(negedge ui_clk);
    chk1("w_accept_busy", fdma_wbusy, 1'b0);
    if (wa + n > DEPTH) exp_err = 1'b1;
    @(posedge ui_clk); #1;
    fdma_wareq = 1'b0;
    forever begin
      if (abort_at >= 0 && beat == abort_at) begin
        fdma_wready = 1'b0;
        fdma_rstn   = 1'b0;
        @(posedge ui_clk); #1;
        fdma_rstn   = 1'b1;
        fdma_wready = 1'b1;
        @(negedge ui_clk);
        check_all_zero("abort");
        exp_err     = 1'b0;
        fdma_wready = 1'b0;
        return;
      end
      fdma_wready = ($urandom_range(99) >= stall_pct);
      d           = idx_data ? DW'(beat) : rand_beat();
      fdma_wdata  = d;
      exp_v       = fdma_wready && (left != 0);
      @(negedge ui_clk);
      chk1("w_busy", fdma_wbusy, 1'b1);
      chk1("w_valid", fdma_wvalid, exp_v);
      if (exp_v) begin
        model_mem[wa] = d;
        wa   = (wa + 1) % DEPTH;
        left--;
        beat++;
      end
      if (left == 0) break;
      @(posedge ui_clk); #1;
    end
    @(posedge ui_clk); #1;
    fdma_wready = 1'b1;
    @(negedge ui_clk);
    chk1("w_done_busy", fdma_wbusy, 1'b0);
    chk1("w_done_valid", fdma_wvalid, 1'b0);
    chk1("w_err", fdma_err, exp_err);
    fdma_wready = 1'b0;
  endtask

  // Read burst; mode 0: rready=1, mode 1: rready 1,0,0,1 repeating, else random.
  task automatic do_read(input logic [AW-1:0] baddr, input int unsigned n, input int mode);
    int unsigned ra;
    int unsigned got;
    int unsigned cyc;
    bit          prev_stall;
    logic        rr;
    ra         = (baddr >> 4) % DEPTH;
    got        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    @(posedge ui_clk); #1;
    fdma_raddr  = baddr;
    fdma_rsize  = SW'(n);
    fdma_rareq  = 1'b1;
    fdma_rready = 1'b0;
    @(negedge ui_clk);
    chk1("r_accept_busy", fdma_rbusy, 1'b0);
    if (ra + n > DEPTH) exp_err = 1'b1;
    @(posedge ui_clk); #1;
    fdma_rareq = 1'b0;
    forever begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rr = 1'($urandom_range(1));
      endcase
      fdma_rready = rr;
      @(negedge ui_clk);
      chk1("r_busy", fdma_rbusy, 1'b1);
      if (mode == 0)   chk1("r_valid_timing", fdma_rvalid, (cyc >= 1) && (cyc <= n));
      else if (n == 0) chk1("r_valid_zero", fdma_rvalid, 1'b0);
      if (prev_stall)  chk1("r_hold_valid", fdma_rvalid, 1'b1);
      if (fdma_rvalid) chk("r_data", fdma_rdata, model_mem[(ra + got) % DEPTH]);
      prev_stall = fdma_rvalid && !rr;
      if (fdma_rvalid && rr) got++;
      if (got == n) break;
      cyc++;
      if (cyc > n * 8 + 50) begin
        chk("r_timeout_beats", DW'(got), DW'(n));
        break;
      end
      @(posedge ui_clk); #1;
    end
    @(posedge ui_clk); #1;
    @(negedge ui_clk);
    chk1("r_done_busy", fdma_rbusy, 1'b0);
    chk1("r_done_valid", fdma_rvalid, 1'b0);
    chk1("r_err", fdma_err, exp_err);
    fdma_rready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fdma_rstn   = 1'b0;
    fdma_waddr  = '0;
    fdma_wareq  = 1'b0;
    fdma_wsize  = '0;
    fdma_wdata  = '0;
    fdma_wready = 1'b0;
    fdma_raddr  = '0;
    fdma_rareq  = 1'b0;
    fdma_rsize  = '0;
    fdma_rready = 1'b0;
    repeat (3) @(posedge ui_clk);
    @(negedge ui_clk);
    check_all_zero("reset");
    @(posedge ui_clk); #1;
    fdma_rstn = 1'b1;

    // Full burst with index data, then full-speed readback.
    do_write(32'h0, 512, 0, 1'b1, -1);
    do_read(32'h0, 512, 0);

    // Short bursts under write and read backpressure.
    do_write(32'h0001_0300, 8, 50, 1'b0, -1);
    do_read(32'h0001_0300, 8, 1);
    do_read(32'h0001_0300, 8, 2);

    // Wrap past the top of memory sets the sticky error.
    do_write(32'(4094 << 4), 4, 30, 1'b0, -1);
    do_read(32'(4094 << 4), 4, 2);
    do_read(32'h0, 2, 0);

    // Concurrent write and read on disjoint regions.
    fork
      do_write(32'h2000, 64, 20, 1'b0, -1);
      do_read(32'h0, 64, 2);
    join
    do_read(32'h2000, 64, 1);

    // Zero-length requests.
    do_write(32'h40, 0, 0, 1'b0, -1);
    do_read(32'h40, 0, 0);
    do_read(32'h40, 0, 2);

    // Reset during a burst, then normal operation resumes.
    do_write(32'h8000, 512, 0, 1'b1, 100);
    do_read(32'h8000, 100, 0);
    do_write(32'h8000, 16, 25, 1'b0, -1);
    do_read(32'h8000, 16, 0);

    for (int i = 0; i < 6; i++) begin
      logic [AW-1:0] a;
      int unsigned   n;
      a = $urandom();
      n = $urandom_range(40, 1);
      do_write(a, n, 40, 1'b0, -1);
      do_read(a, n, i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
